div_issue_ctrl: RTL

EX-stage controller that sits directly upstream of the iterative divider. It decodes a valid DIV/DIVU request and drives the divider's start/annul/operand handshake. It holds the pipeline stalled until the divider reports ready, then commits the 64-bit result into the architectural HI/LO registers. It also owns HI/LO and services MTHI/MTLO and multiplier writes.

---
 rtl/div_issue_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
//   EX-stage front end for the iterative divider. Captures a DIV/DIVU
//   request, drives the divider start/annul/operand handshake, stalls the
//   pipeline until the divider returns a result and commits that result to
//   the architectural HI/LO registers. Also owns HI/LO for MTHI/MTLO and
//   multiplier writes.
//
//   Ports
//     clk, rst                 core clock, synchronous active-high reset
//     flush_i                  pipeline flush, aborts any divide in flight
//     stall_i                  downstream stall, holds a completed divide
//     div_req_i/div_signed_i   divide request and signedness from EX
//     rs_i, rt_i               dividend / divisor
//     hi_we_i, lo_we_i         MTHI / MTLO write enables
//     mt_wdata_i               MTHI / MTLO data
//     mul_we_i, mul_result_i   multiplier {HI,LO} write
//     div_start_o/annul_o      divider control
//     div_signed_o/op1_o/op2_o latched divider operands
//     div_result_i/ready_i     divider {remainder,quotient} and valid
//     stall_o                  stall request to hazard unit
//     div_busy_o               a divide is in progress or awaiting retire
//     hi_o, lo_o               architectural HI / LO
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no divide in flight; a request is latched and issued
//   BUSY   | divider running on latched operands; pipeline stalled
//   DONE   | result committed, start dropped; waits for the EX slot to retire

module div_issue_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                stall_i,
    input  logic                div_req_i,
    input  logic                div_signed_i,
    input  logic [DATA_W-1:0]   rs_i,
    input  logic [DATA_W-1:0]   rt_i,
    input  logic                hi_we_i,
    input  logic                lo_we_i,
    input  logic [DATA_W-1:0]   mt_wdata_i,
    input  logic                mul_we_i,
    input  logic [2*DATA_W-1:0] mul_result_i,
    output logic                div_start_o,
    output logic                div_annul_o,
    output logic                div_signed_o,
    output logic [DATA_W-1:0]   div_op1_o,
    output logic [DATA_W-1:0]   div_op2_o,
    input  logic [2*DATA_W-1:0] div_result_i,
    input  logic                div_ready_i,
    output logic                stall_o,
    output logic                div_busy_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic                r_signed;
    logic [DATA_W-1:0]   r_op1;
    logic [DATA_W-1:0]   r_op2;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_load_ops;
    logic                w_div_commit;

    // Operands are captured only on issue; they are never re-sampled while
    // the divider runs, so EX may change rs/rt freely during the stall.
    assign w_load_ops   = (r_state == S_IDLE) & div_req_i & ~flush_i;
    // A flush in the ready cycle kills the commit.
    assign w_div_commit = (r_state == S_BUSY) & div_ready_i & ~flush_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush wins over everything, including stall_i
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (div_req_i && !flush_i) begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    w_next_state = S_IDLE;
                end else if (div_ready_i) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (flush_i || !stall_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        div_start_o = 1'b0;
        div_annul_o = 1'b0;
        stall_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall_o = div_req_i & ~flush_i;
            end
            S_BUSY: begin
                div_start_o = ~flush_i;
                div_annul_o = flush_i;
                stall_o     = 1'b1;
            end
            default: begin
                div_start_o = 1'b0;
            end
        endcase
    end

    assign div_busy_o   = (r_state != S_IDLE);
    assign div_signed_o = r_signed;
    assign div_op1_o    = r_op1;
    assign div_op2_o    = r_op2;
    assign hi_o         = r_hi;
    assign lo_o         = r_lo;

    // Operand latches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_signed <= 1'b0;
            r_op1    <= '0;
            r_op2    <= '0;
        end else if (w_load_ops) begin
            r_signed <= div_signed_i;
            r_op1    <= rs_i;
            r_op2    <= rt_i;
        end
    end

    // HI/LO: divide commit beats multiplier, multiplier beats MTHI/MTLO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (w_div_commit) begin
                r_hi <= div_result_i[2*DATA_W-1:DATA_W];
            end else if (mul_we_i) begin
                r_hi <= mul_result_i[2*DATA_W-1:DATA_W];
            end else if (hi_we_i) begin
                r_hi <= mt_wdata_i;
            end

            if (w_div_commit) begin
                r_lo <= div_result_i[DATA_W-1:0];
            end else if (mul_we_i) begin
                r_lo <= mul_result_i[DATA_W-1:0];
            end else if (lo_we_i) begin
                r_lo <= mt_wdata_i;
            end
        end
    end

endmodule
